// File: rtl/xor_gate_pkg.sv
// -----------------------------------------------------------------------------
// xor_gate_pkg
//   Shared constants and helpers for the xor_gate block.
//
//   DEF_WIDTH  : default operand/result width of xor_gate.
//   DEF_CNT_W  : default width of the saturating mismatch counter.
//   sat_max    : all-ones value for a counter of a given width.
//   sat_step   : next value of an unsigned saturating up-counter.
// -----------------------------------------------------------------------------
package xor_gate_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_CNT_W = 8;

  // Largest value a counter of CNT_W bits can hold (all ones).
  function automatic logic [31:0] sat_max(input int cnt_w);
    logic [31:0] max_v;
    max_v = '0;
    for (int i = 0; i < cnt_w && i < 32; i++) begin
      max_v[i] = 1'b1;
    end
    return max_v;
  endfunction

  // Unsigned saturating increment: returns cur+1 unless cur is already
  // at max_v, in which case it returns cur unchanged.
  function automatic logic [31:0] sat_step(input logic [31:0] cur,
                                           input logic [31:0] max_v);
    logic [31:0] nxt;
    if (cur == max_v) begin
      nxt = cur;
    end else begin
      nxt = cur + 32'd1;
    end
    return nxt;
  endfunction

endpackage : xor_gate_pkg

// File: rtl/xor_sat_counter.sv
// -----------------------------------------------------------------------------
// xor_sat_counter
//   Unsigned up-counter that saturates at all ones instead of wrapping.
//
//   Parameters
//     WIDTH : counter width in bits (>= 1, <= 32).
//   Ports
//     clk    in   1      rising-edge clock
//     rst_n  in   1      asynchronous active-low reset, clears count to 0
//     inc    in   1      count one on this edge (if not saturated)
//     count  out  WIDTH  current count
// -----------------------------------------------------------------------------
module xor_sat_counter
  import xor_gate_pkg::*;
#(
  parameter int WIDTH = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [31:0] MAX_32 = sat_max(WIDTH);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic [31:0]      count_ext;
  logic [31:0]      step_ext;

  // Do the saturating step in a fixed 32-bit domain so the helper can be
  // shared by any counter width; the upper bits are always zero.
  assign count_ext = 32'(count_reg);
  assign step_ext  = sat_step(count_ext, MAX_32);

  always_comb begin
    count_next = count_reg;
    if (inc) begin
      count_next = step_ext[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

  // Upper bits of the 32-bit step are unused by construction when WIDTH < 32.
  logic unused_step;
  assign unused_step = ^step_ext;

endmodule : xor_sat_counter

// File: rtl/xor_gate.sv
// -----------------------------------------------------------------------------
// xor_gate
//   Bitwise XOR of two operands with a registered copy, registered parity,
//   a change-detect pulse and a saturating count of mismatching cycles.
//
//   Parameters
//     WIDTH : operand/result width (default DEF_WIDTH).
//     CNT_W : mismatch counter width (default DEF_CNT_W).
//   Ports
//     clk       in   1      rising-edge clock
//     rst_n     in   1      asynchronous active-low reset (synchronised
//                           externally; no synchroniser in this block)
//     a         in   WIDTH  first operand
//     b         in   WIDTH  second operand
//     y         out  WIDTH  combinational a ^ b, independent of clk/rst_n
//     y_q       out  WIDTH  y registered one cycle
//     parity_q  out  1      registered reduction XOR of y
//     toggle    out  1      high for one cycle after y_q changes value
//     diff_cnt  out  CNT_W  saturating count of edges with y nonzero
// -----------------------------------------------------------------------------
module xor_gate
  import xor_gate_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             parity_q,
  output logic             toggle,
  output logic [CNT_W-1:0] diff_cnt
);

  logic [WIDTH-1:0] y_comb;
  logic [WIDTH-1:0] par_chain;

  // Per-bit XOR and a running parity chain; par_chain[WIDTH-1] is ^y.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign y_comb[gi] = a[gi] ^ b[gi];
      if (gi == 0) begin : g_first
        assign par_chain[gi] = y_comb[gi];
      end else begin : g_rest
        assign par_chain[gi] = par_chain[gi-1] ^ y_comb[gi];
      end
    end
  endgenerate

  assign y = y_comb;

  logic [WIDTH-1:0] y_q_reg;
  logic [WIDTH-1:0] y_q_next;
  logic             parity_reg;
  logic             parity_next;
  logic             toggle_reg;
  logic             toggle_next;
  logic             y_nonzero;

  // The toggle flag is computed from the value about to be loaded versus
  // the value currently held, so it rises in the same cycle y_q shows the
  // new value. Reset leaves y_q at 0, so the first load after reset pulses
  // only when it loads something nonzero.
  always_comb begin
    y_q_next    = y_comb;
    parity_next = par_chain[WIDTH-1];
    toggle_next = (y_comb != y_q_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q_reg    <= '0;
      parity_reg <= 1'b0;
      toggle_reg <= 1'b0;
    end else begin
      y_q_reg    <= y_q_next;
      parity_reg <= parity_next;
      toggle_reg <= toggle_next;
    end
  end

  assign y_q      = y_q_reg;
  assign parity_q = parity_reg;
  assign toggle   = toggle_reg;

  assign y_nonzero = |y_comb;

  xor_sat_counter #(
    .WIDTH (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (y_nonzero),
    .count (diff_cnt)
  );

endmodule : xor_gate

// File: tb/tb_xor_gate.sv
// -----------------------------------------------------------------------------
// tb_xor_gate
//   Directed bench for xor_gate. Three instances share one clock:
//     u_d1 : WIDTH=1, CNT_W=8  (truth table, reset, toggle, async reset)
//     u_d2 : WIDTH=1, CNT_W=2  (saturation)
//     u_d4 : WIDTH=4, CNT_W=8  (multi-bit parity)
//   Inputs change on the falling edge; outputs are sampled 1 time unit
//   after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_xor_gate;

  logic clk;
  logic clk_en;

  logic       rst_n1, a1, b1, y1, yq1, par1, tog1;
  logic [7:0] cnt1;

  logic       rst_n2, a2, b2, y2, yq2, par2, tog2;
  logic [1:0] cnt2;

  logic       rst_n4;
  logic [3:0] a4, b4, y4, yq4;
  logic       par4, tog4;
  logic [7:0] cnt4;

  int n_checks;
  int n_fail;

  xor_gate #(.WIDTH(1), .CNT_W(8)) u_d1 (
    .clk(clk), .rst_n(rst_n1), .a(a1), .b(b1), .y(y1), .y_q(yq1),
    .parity_q(par1), .toggle(tog1), .diff_cnt(cnt1)
  );

  xor_gate #(.WIDTH(1), .CNT_W(2)) u_d2 (
    .clk(clk), .rst_n(rst_n2), .a(a2), .b(b2), .y(y2), .y_q(yq2),
    .parity_q(par2), .toggle(tog2), .diff_cnt(cnt2)
  );

  xor_gate #(.WIDTH(4), .CNT_W(8)) u_d4 (
    .clk(clk), .rst_n(rst_n4), .a(a4), .b(b4), .y(y4), .y_q(yq4),
    .parity_q(par4), .toggle(tog4), .diff_cnt(cnt4)
  );

  // Clock is held idle until clk_en is set.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_truth_table();
    logic [1:0] va [4];
    logic       ve [4];
    va[0] = 2'b00; ve[0] = 1'b0;
    va[1] = 2'b01; ve[1] = 1'b1;
    va[2] = 2'b10; ve[2] = 1'b1;
    va[3] = 2'b11; ve[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a1 = va[i][1];
      b1 = va[i][0];
      #10;
      n_checks++;
      if (y1 !== ve[i]) begin
        n_fail++;
        $display("FAIL truth_table a=%b b=%b: y got %b expected %b", a1, b1, y1, ve[i]);
      end else begin
        $display("truth_table a=%b b=%b y=%b", a1, b1, y1);
      end
    end
  endtask

  task automatic test_reset();
    rst_n1 = 1'b0;
    a1 = 1'b1;
    b1 = 1'b0;
    #3;
    n_checks++;
    if (y1 !== 1'b1 || yq1 !== 1'b0 || par1 !== 1'b0 || tog1 !== 1'b0 || cnt1 !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_hold: y=%b y_q=%b par=%b tog=%b cnt=%0d expected y=1 rest 0",
               y1, yq1, par1, tog1, cnt1);
    end else begin
      $display("reset_hold y=%b y_q=%b par=%b tog=%b cnt=%0d", y1, yq1, par1, tog1, cnt1);
    end
  endtask

  task automatic test_count_toggle();
    logic       exp_yq  [5];
    logic       exp_tog [5];
    logic [7:0] exp_cnt [5];
    exp_yq[0] = 1; exp_tog[0] = 1; exp_cnt[0] = 1;
    exp_yq[1] = 1; exp_tog[1] = 0; exp_cnt[1] = 2;
    exp_yq[2] = 1; exp_tog[2] = 0; exp_cnt[2] = 3;
    exp_yq[3] = 0; exp_tog[3] = 1; exp_cnt[3] = 3;
    exp_yq[4] = 0; exp_tog[4] = 0; exp_cnt[4] = 3;
    @(negedge clk);
    rst_n1 = 1'b1;
    a1 = 1'b1;
    b1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (yq1 !== exp_yq[i] || tog1 !== exp_tog[i] || cnt1 !== exp_cnt[i] || par1 !== exp_yq[i]) begin
        n_fail++;
        $display("FAIL count_toggle edge %0d: y_q=%b tog=%b cnt=%0d par=%b expected y_q=%b tog=%b cnt=%0d par=%b",
                 i, yq1, tog1, cnt1, par1, exp_yq[i], exp_tog[i], exp_cnt[i], exp_yq[i]);
      end else begin
        $display("count_toggle edge %0d y_q=%b tog=%b cnt=%0d", i, yq1, tog1, cnt1);
      end
      if (i == 2) begin
        @(negedge clk);
        b1 = 1'b1;
      end
    end
  endtask

  task automatic test_mid_cycle();
    // y is 0 here; a glitch between edges must not reach registered state.
    @(negedge clk);
    a1 = 1'b0;
    #1;
    a1 = 1'b1;
    tick();
    n_checks++;
    if (cnt1 !== 8'd3 || yq1 !== 1'b0 || tog1 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_cycle_glitch: cnt=%0d y_q=%b tog=%b expected cnt=3 y_q=0 tog=0", cnt1, yq1, tog1);
    end else begin
      $display("mid_cycle_glitch cnt=%0d y_q=%b", cnt1, yq1);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt [6];
    exp_cnt[0] = 1; exp_cnt[1] = 2; exp_cnt[2] = 3;
    exp_cnt[3] = 3; exp_cnt[4] = 3; exp_cnt[5] = 3;
    @(negedge clk);
    rst_n2 = 1'b1;
    a2 = 1'b0;
    b2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (cnt2 !== exp_cnt[i]) begin
        n_fail++;
        $display("FAIL saturate edge %0d: cnt got %0d expected %0d", i, cnt2, exp_cnt[i]);
      end else begin
        $display("saturate edge %0d cnt=%0d", i, cnt2);
      end
    end
  endtask

  task automatic test_wide();
    @(negedge clk);
    rst_n4 = 1'b1;
    a4 = 4'b1010;
    b4 = 4'b0110;
    #1;
    n_checks++;
    if (y4 !== 4'b1100) begin
      n_fail++;
      $display("FAIL wide_y0: y got %b expected 1100", y4);
    end else begin
      $display("wide_y0 y=%b", y4);
    end
    tick();
    n_checks++;
    if (yq4 !== 4'b1100 || par4 !== 1'b0 || cnt4 !== 8'd1) begin
      n_fail++;
      $display("FAIL wide_reg0: y_q=%b par=%b cnt=%0d expected y_q=1100 par=0 cnt=1", yq4, par4, cnt4);
    end else begin
      $display("wide_reg0 y_q=%b par=%b", yq4, par4);
    end
    @(negedge clk);
    b4 = 4'b0010;
    #1;
    n_checks++;
    if (y4 !== 4'b1000) begin
      n_fail++;
      $display("FAIL wide_y1: y got %b expected 1000", y4);
    end else begin
      $display("wide_y1 y=%b", y4);
    end
    tick();
    n_checks++;
    if (yq4 !== 4'b1000 || par4 !== 1'b1 || tog4 !== 1'b1) begin
      n_fail++;
      $display("FAIL wide_reg1: y_q=%b par=%b tog=%b expected y_q=1000 par=1 tog=1", yq4, par4, tog4);
    end else begin
      $display("wide_reg1 y_q=%b par=%b tog=%b", yq4, par4, tog4);
    end
  endtask

  task automatic test_async_reset();
    // Fresh count to 5 on u_d1.
    @(negedge clk);
    rst_n1 = 1'b0;
    a1 = 1'b1;
    b1 = 1'b0;
    #1;
    rst_n1 = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (cnt1 !== 8'd5) begin
      n_fail++;
      $display("FAIL async_pre: cnt got %0d expected 5", cnt1);
    end else begin
      $display("async_pre cnt=%0d", cnt1);
    end
    #2;
    rst_n1 = 1'b0;
    #1;
    n_checks++;
    if (yq1 !== 1'b0 || par1 !== 1'b0 || tog1 !== 1'b0 || cnt1 !== 8'd0 || y1 !== 1'b1) begin
      n_fail++;
      $display("FAIL async_clear: y=%b y_q=%b par=%b tog=%b cnt=%0d expected y=1 rest 0",
               y1, yq1, par1, tog1, cnt1);
    end else begin
      $display("async_clear y_q=%b cnt=%0d", yq1, cnt1);
    end
    @(negedge clk);
    rst_n1 = 1'b1;
    tick();
    n_checks++;
    if (cnt1 !== 8'd1 || yq1 !== 1'b1 || tog1 !== 1'b1) begin
      n_fail++;
      $display("FAIL async_resume: cnt=%0d y_q=%b tog=%b expected cnt=1 y_q=1 tog=1", cnt1, yq1, tog1);
    end else begin
      $display("async_resume cnt=%0d", cnt1);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clk_en   = 1'b0;
    rst_n1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    rst_n2 = 1'b0; a2 = 1'b0; b2 = 1'b0;
    rst_n4 = 1'b0; a4 = '0;   b4 = '0;

    test_truth_table();
    test_reset();
    clk_en = 1'b1;
    test_count_toggle();
    test_mid_cycle();
    test_saturate();
    test_wide();
    test_async_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net against a stalled clock.
  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded 20000 time units");
    $fatal(1, "timeout");
  end

endmodule : tb_xor_gate
